serial_bit_feeder: RTL and testbench
====================================

# serial_bit_feeder

Parallel-to-serial feeder that sits directly upstream of the 101 sequence-detector FSMs. It accepts WIDTH-bit words over a valid/ready handshake and drives them onto a single-bit stream `x`, one bit per clock. The detector samples `x` every cycle, so this block holds a defined idle level between words. Word boundaries are flagged for downstream alignment checks.

## Interface
- `WIDTH`, default 8: data word width, legal range 2..32.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- `IDLE_BIT`, default 0: level driven on `x` when no word is being shifted.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `din`  in  WIDTH  parallel word.
- `din_valid`  in  1  `din` holds a word to transfer.
- `din_ready`  out  1  the block can capture `din` on this edge.
- `x`  out  1  serial bit, registered; connects to the detector `x` input.
- `x_valid`  out  1  `x` carries a data (or parity) bit this cycle.
- `frame_start`  out  1  `x` carries the first bit of a word this cycle.
- `busy`  out  1  the block is in SHIFT state.

## Operation
- Transfer: a word is captured on a rising edge where `din_valid && din_ready`. `din` is sampled only on that edge.
- States:
  - IDLE:
    - `din_ready`=1.
    - On a transfer, load the shift register, set the bit counter to 0, and go to SHIFT.
  - SHIFT:
    - Each cycle, present the next bit on `x` and increment the counter.
    - On the final bit cycle (counter = FRAME_LEN-1), `din_ready`=1.
    - A transfer on that edge reloads the word and stays in SHIFT, giving a gapless stream.
    - With no transfer on that edge, return to IDLE.
- FRAME_LEN = WIDTH, or WIDTH+1 when parity is enabled.
- Bit counter width is clog2(FRAME_LEN+1). The counter never wraps past FRAME_LEN-1.
- Output bit order:
  - MSB_FIRST=1: `din[WIDTH-1]`, then `din[WIDTH-2]`, down to `din[0]`.
  - MSB_FIRST=0: the reverse order.
- In IDLE: `x`=IDLE_BIT, `x_valid`=0, `frame_start`=0.
- `din_valid` deasserting without a transfer has no effect. No word is ever dropped or duplicated.

## Timing
- Reset values (while `reset_n`=0):
  - Outputs: `x`=IDLE_BIT, `x_valid`=0, `frame_start`=0, `busy`=0, `din_ready`=0.
  - State is IDLE; counter and shift register are 0.
- First ready edge: `din_ready` rises on the first rising edge after `reset_n` deasserts. It is driven from an enable flop, so no capture can happen in the reset-release cycle.
- Latency: a word transferred on edge N drives its first bit on `x` (with `frame_start`=1) in the cycle after edge N.
- Word duration: the last bit occupies the cycle after edge N+FRAME_LEN-1.
- Throughput: back-to-back words produce one bit per cycle with no idle gap.
- `frame_start` is high for exactly one cycle per word.
- `x_valid` and `busy` stay high continuously across back-to-back words.
- Reset mid-word: the partial word is discarded and all outputs take their reset values immediately (asynchronously). No residual bits appear after release.
- `din_ready` is combinational from state and counter only; it never depends on `din_valid`.

## Configuration
- Macro: `SERIAL_BIT_FEEDER_PARITY_EN`.
- Defined:
  - An even-parity bit (XOR of all WIDTH data bits) is appended after the last data bit.
  - FRAME_LEN = WIDTH+1. `x_valid`=1 during the parity cycle.
  - The `din_ready` overlap moves to the parity cycle.
- Undefined:
  - No parity cycle; FRAME_LEN = WIDTH.
  - No parity logic is synthesized.

## Test plan
- Single word (WIDTH=8, MSB_FIRST=1, parity off): `din`=8'hA5 transferred on edge 0 → `x` = 1,0,1,0,0,1,0,1 in cycles 1..8. `frame_start`=1 only in cycle 1. `x`=0 and `x_valid`=0 from cycle 9.
- Back-to-back words: 8'hA5, then 8'h3C held valid → 8'h3C captured on edge 8 and `x` = 0,0,1,1,1,1,0,0 in cycles 9..16. `x_valid` stays high for cycles 1..16; `frame_start` is high in cycles 1 and 9.
- LSB first (MSB_FIRST=0): `din`=8'h05 → `x` = 1,0,1,0,0,0,0,0. The downstream 101 detector asserts `y` once, after the third bit.
- Parity (macro defined): 8'hA5 → 8 data bits then 0 in cycle 9. 8'h07 → parity bit 1. `din_ready`=1 in cycle 9 only.
- Reset mid-word: assert `reset_n`=0 during cycle 4 of 8'hFF → `x`=IDLE_BIT and `busy`=0 immediately. After release, `din_ready`=0 for one cycle, then 1. The next word 8'h81 streams cleanly as 1,0,0,0,0,0,0,1.
- Stall: hold `din_valid`=0 for 5 cycles between words → `x`=IDLE_BIT and `x_valid`=0 throughout the gap, and the second word's first bit follows its transfer edge by one cycle.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the 101 detector: WIDTH-bit words in over valid/ready, one bit per clock out on x.
// Optional even-parity trailer bit is enabled by defining SERIAL_BIT_FEEDER_PARITY_EN.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
`endif

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic             x_r, x_s;
  logic             x_valid_r, x_valid_s;
  logic             frame_start_r, frame_start_s;
  logic             ready_en_r;
  logic             transfer_s;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  logic             parity_r, parity_s;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return w[WIDTH-1];
    else           return w[0];
  endfunction

  // Drops the bit just presented so the next one sits at the output end.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return {w[WIDTH-2:0], 1'b0};
    else           return {1'b0, w[WIDTH-1:1]};
  endfunction

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  assign din_ready  = ready_en_r &&
                      ((state_r == IDLE) || ((state_r == SHIFT) && (cnt_r == LAST_CNT)));
  assign transfer_s = din_valid && din_ready;

  // Next-state and next-output logic; a transfer is only possible in IDLE or on the last frame bit.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    shift_s       = shift_r;
    x_s           = IDLE_BIT;
    x_valid_s     = 1'b0;
    frame_start_s = 1'b0;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    parity_s      = parity_r;
`endif
    if (transfer_s) begin
      state_s       = SHIFT;
      cnt_s         = {CNT_W{1'b0}};
      x_s           = first_bit(din);
      shift_s       = advance(din);
      x_valid_s     = 1'b1;
      frame_start_s = 1'b1;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
      parity_s      = even_parity(din);
`endif
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        SHIFT: begin
          if (cnt_r == LAST_CNT) begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_s     = cnt_r + CNT_W'(1);
            x_valid_s = 1'b1;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
            if (cnt_r == DATA_LAST) begin
              x_s = parity_r;
            end else begin
              x_s     = first_bit(shift_r);
              shift_s = advance(shift_r);
            end
`else
            x_s     = first_bit(shift_r);
            shift_s = advance(shift_r);
`endif
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, datapath and registered outputs; reset discards any partial word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      shift_r       <= {WIDTH{1'b0}};
      x_r           <= IDLE_BIT;
      x_valid_r     <= 1'b0;
      frame_start_r <= 1'b0;
      ready_en_r    <= 1'b0;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
      parity_r      <= 1'b0;
`endif
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      shift_r       <= shift_s;
      x_r           <= x_s;
      x_valid_r     <= x_valid_s;
      frame_start_r <= frame_start_s;
      ready_en_r    <= 1'b1;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
      parity_r      <= parity_s;
`endif
    end
  end

  assign x           = x_r;
  assign x_valid     = x_valid_r;
  assign frame_start = frame_start_r;
  assign busy        = (state_r == SHIFT);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: an MSB-first/idle-0 and an LSB-first/idle-1 instance share stimulus,
// checked against a queue-based frame model plus a hand-derived vector table.
module tb_serial_bit_feeder;
  localparam int W = 8;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         rdy0, x0, xv0, fs0, busy0;
  logic         rdy1, x1, xv1, fs1, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid), .din_ready(rdy0),
    .x(x0), .x_valid(xv0), .frame_start(fs0), .busy(busy0));

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid), .din_ready(rdy1),
    .x(x1), .x_valid(xv1), .frame_start(fs1), .busy(busy1));

  // Reference model: each instance owns a queue of bits still to be shown after the current one.
  bit   mq[2][$];
  logic ex_x[2], ex_xv[2], ex_fs[2];
  bit   en;

  function automatic logic idle_of(int i);
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic bit model_ready();
    return en && (mq[0].size() == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      ex_x[i] = idle_of(i); ex_xv[i] = 1'b0; ex_fs[i] = 1'b0;
    end
    en = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [W-1:0] d);
    bit take;
    take = v && model_ready();
    for (int i = 0; i < 2; i++) begin
      if (take) begin
        mq[i].delete();
        for (int b = 0; b < W; b++) mq[i].push_back((i == 0) ? d[W-1-b] : d[b]);
        if (PAR) mq[i].push_back(^d);
        ex_x[i] = mq[i].pop_front(); ex_xv[i] = 1'b1; ex_fs[i] = 1'b1;
      end else if (mq[i].size() > 0) begin
        ex_x[i] = mq[i].pop_front(); ex_xv[i] = 1'b1; ex_fs[i] = 1'b0;
      end else begin
        ex_x[i] = idle_of(i); ex_xv[i] = 1'b0; ex_fs[i] = 1'b0;
      end
    end
    en = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("ready0", rdy0, model_ready());
    chk("ready1", rdy1, model_ready());
    chk("x0", x0, ex_x[0]);   chk("xv0", xv0, ex_xv[0]);
    chk("fs0", fs0, ex_fs[0]); chk("busy0", busy0, ex_xv[0]);
    chk("x1", x1, ex_x[1]);   chk("xv1", xv1, ex_xv[1]);
    chk("fs1", fs1, ex_fs[1]); chk("busy1", busy1, ex_xv[1]);
  endtask

  // Called at a falling edge: check, drive, take the rising edge, return at the next falling edge.
  task automatic cycle(input logic v, input logic [W-1:0] d);
    check_model();
    din_valid = v; din = d;
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_x0"}, x0, 1'b0);  chk({tag, "_x1"}, x1, 1'b1);
    chk({tag, "_xv"}, {xv0, xv1}, 2'b00);
    chk({tag, "_fs"}, {fs0, fs1}, 2'b00);
    chk({tag, "_busy"}, {busy0, busy1}, 2'b00);
    chk({tag, "_rdy"}, {rdy0, rdy1}, 2'b00);
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         rdy;
    logic         x;
    logic         xv;
    logic         fs;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [W-1:0] d, input logic rdy,
                     input logic x, input logic xv, input logic fs);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.x = x; r.xv = xv; r.fs = fs;
    tbl.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a5, c3c, e81, s;
    int n101;

    // MSB-first stream: A5, 3C held valid (captured on the last A5 bit), idle gap, then 81.
    a5 = 8'hA5; c3c = 8'h3C; e81 = 8'h81;
    add(1'b1, a5, 1'b1, a5[7], 1'b1, 1'b1);
    for (int k = 1; k < 8; k++) add(1'b1, c3c, 1'b0, a5[7-k], 1'b1, 1'b0);
    add(1'b1, c3c, 1'b1, c3c[7], 1'b1, 1'b1);
    for (int k = 1; k < 8; k++) add(1'b0, 8'hFF, 1'b0, c3c[7-k], 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) add(1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, e81, 1'b1, e81[7], 1'b1, 1'b1);
    for (int k = 1; k < 8; k++) add(1'b0, 8'h00, 1'b0, e81[7-k], 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    model_reset();
    @(negedge clk);
    check_reset_vals("rst");
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b1, 8'h11);          // ready still low in the release cycle: must not capture
    cycle(1'b0, 8'h00);

`ifndef SERIAL_BIT_FEEDER_PARITY_EN
    foreach (tbl[i]) begin
      chk($sformatf("tbl%0d_rdy", i), rdy0, tbl[i].rdy);
      cycle(tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_x", i), x0, tbl[i].x);
      chk($sformatf("tbl%0d_xv", i), xv0, tbl[i].xv);
      chk($sformatf("tbl%0d_fs", i), fs0, tbl[i].fs);
    end
`endif

    // LSB-first 05 on the second instance: stream 1,0,1,0,0,0,0,0 contains exactly one 101.
    cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h05);
    s[0] = x1;
    for (int k = 1; k < 8; k++) begin
      cycle(1'b0, 8'h00);
      s[k] = x1;
    end
    chk("lsb_stream", s, 8'h05);
    n101 = 0;
    for (int k = 0; k < 6; k++) if (s[k] && !s[k+1] && s[k+2]) n101++;
    chk("lsb_101_count", n101, 1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00);

    // Reset in the fourth bit cycle of FF, then 81 must stream cleanly.
    cycle(1'b1, 8'hFF);
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00);
    chk("pre_rst_busy", busy0, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("hold");
    reset_n = 1'b1;
    cycle(1'b1, 8'h81);
    cycle(1'b1, 8'h81);
    for (int k = 0; k < 10; k++) cycle(1'b0, 8'h00);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++)
      cycle(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, W'($urandom));
    for (int k = 0; k < 12; k++) cycle(1'b0, 8'h00);
    check_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
